// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcode constants for the immediate generator stage
package imm_gen_pkg;

    localparam int XLEN_MAX = 64;
    localparam int NUM_FMT  = 6;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Fields sized for the widest datapath; narrower builds zero the upper bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] target;
        logic                illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_if.sv
// rtl/imm_gen_if.sv - instruction-in / decoded-immediate-out handshake bundle
interface imm_gen_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_fifo.sv
// rtl/imm_gen_fifo.sv - DEPTH-entry FIFO of decoded entries with flush and async reset
module imm_gen_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Flush wins over both push and pop in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - RISC-V immediate/format/target decode into an output FIFO; IMM_GEN_PERF_EN adds per-format pop counters
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    imm_gen_if.slave                     bus
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [NUM_FMT-1:0][15:0]     perf_cnt
`endif
);
    logic [31:0]        inst;
    logic [6:0]         opcode;
    fmt_e               fmt;
    logic               illegal;
    logic               use_target;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    target;
    imm_entry_t         wr_entry;
    imm_entry_t         head;
    logic               push, pop, full, empty;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        fmt        = FMT_NONE;
        illegal    = 1'b0;
        use_target = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD, OPC_OP_IMM, OPC_JALR,
                OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
                OPC_STORE:                fmt = FMT_S;
                OPC_BRANCH: begin
                    fmt        = FMT_B;
                    use_target = 1'b1;
                end
                OPC_LUI:                  fmt = FMT_U;
                OPC_AUIPC: begin
                    fmt        = FMT_U;
                    use_target = 1'b1;
                end
                OPC_JAL: begin
                    fmt        = FMT_J;
                    use_target = 1'b1;
                end
                OPC_OP:                   fmt = FMT_NONE;
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) fmt = FMT_I;
                    else            illegal = 1'b1;
                end
                OPC_OP_32: begin
                    if (XLEN != 64) illegal = 1'b1;
                end
                default:                  illegal = 1'b1;
            endcase
        end
    end

    // Signed 32-bit immediates sign-extend to XLEN through the size cast.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = XLEN'(imm_i);
            FMT_S:   imm = XLEN'(imm_s);
            FMT_B:   imm = XLEN'(imm_b);
            FMT_U:   imm = XLEN'(imm_u);
            FMT_J:   imm = XLEN'(imm_j);
            default: imm = '0;
        endcase
    end

    assign target = use_target ? (bus.in_pc + imm) : '0;

    always_comb begin
        wr_entry         = '0;
        wr_entry.imm     = XLEN_MAX'(imm);
        wr_entry.fmt     = fmt;
        wr_entry.target  = XLEN_MAX'(target);
        wr_entry.illegal = illegal;
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    imm_gen_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (imm_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    // Storage is not reset, so payload outputs are forced to zero while empty.
    assign bus.out_imm     = bus.out_valid ? head.imm[XLEN-1:0]    : '0;
    assign bus.out_fmt     = bus.out_valid ? head.fmt              : FMT_NONE;
    assign bus.out_target  = bus.out_valid ? head.target[XLEN-1:0] : '0;
    assign bus.out_illegal = bus.out_valid ? head.illegal          : 1'b0;

    if (XLEN < XLEN_MAX) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^{head.imm[XLEN_MAX-1:XLEN], head.target[XLEN_MAX-1:XLEN]};
    end

`ifdef IMM_GEN_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (pop && !bus.flush) begin
            if (perf_cnt[head.fmt] != 16'hFFFF)
                perf_cnt[head.fmt] <= perf_cnt[head.fmt] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage (XLEN=32, DEPTH=2)
module tb_imm_gen_stage;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(XLEN)) bus();
`ifdef IMM_GEN_PERF_EN
    logic [5:0][15:0] perf_cnt;
`endif

    imm_gen_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef IMM_GEN_PERF_EN
        ,
        .perf_cnt (perf_cnt)
`endif
    );

    exp_t exp_q[$];
    exp_t pend;
    int   mdl_cnt = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    logic [6:0] legal_ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                   7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e = '0;
        if (inst[1:0] != 2'b11) begin
            e.illegal = 1'b1;
            return e;
        end
        case (inst[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                e.fmt = 3'd1;
                e.imm = 32'($signed(inst) >>> 20);
            end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                e.fmt    = 3'd3;
                e.imm    = (32'($signed(inst) >>> 31) << 12) | (32'(inst[7]) << 11)
                         | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
                e.target = pc + e.imm;
            end
            7'h37: begin
                e.fmt = 3'd4;
                e.imm = inst & 32'hFFFFF000;
            end
            7'h17: begin
                e.fmt    = 3'd4;
                e.imm    = inst & 32'hFFFFF000;
                e.target = pc + e.imm;
            end
            7'h6F: begin
                e.fmt    = 3'd5;
                e.imm    = (32'($signed(inst) >>> 31) << 20) | (32'(inst[19:12]) << 12)
                         | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
                e.target = pc + e.imm;
            end
            7'h33: e.fmt = 3'd0;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        pend         = model(inst, pc);
    endtask

    // Advances one clock and updates the scoreboard from the inputs currently driven.
    task automatic tick();
        logic acc, pop;
        acc = bus.in_valid && (mdl_cnt < DEPTH) && !bus.flush;
        pop = (mdl_cnt > 0) && bus.out_ready && !bus.flush;
        @(posedge clk);
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(pend);
        end
        mdl_cnt = exp_q.size();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: out_valid=%b want 0", bus.out_valid);
        end
        n_chk++;
        if ({bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: imm=%h fmt=%0d tgt=%h ill=%b want all zero",
                     bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal);
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_spec_vectors();
        logic [31:0] v_inst [4] = '{32'hFFF00093, 32'hFFDFF06F, 32'h00000463, 32'hFFFFF097};
        logic [31:0] v_pc   [4] = '{32'h0, 32'h100, 32'h200, 32'h1000};
        exp_t        v_exp  [4] = '{'{32'hFFFFFFFF, 3'd1, 32'h0,   1'b0},
                                    '{32'hFFFFFFFC, 3'd5, 32'hFC,  1'b0},
                                    '{32'h00000008, 3'd3, 32'h208, 1'b0},
                                    '{32'hFFFFF000, 3'd4, 32'h0,   1'b0}};
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                drive(1'b1, v_inst[i], v_pc[i]);
                pend = v_exp[i];
            end else begin
                drive(1'b0, 32'h0, 32'h0);
            end
            if (i > 0) begin
                n_chk++;
                if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal}
                    !== {1'b1, v_exp[i-1]}) begin
                    n_fail++;
                    $display("FAIL vector%0d: got v=%b imm=%h fmt=%0d tgt=%h ill=%b want imm=%h fmt=%0d tgt=%h",
                             i-1, bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal,
                             v_exp[i-1].imm, v_exp[i-1].fmt, v_exp[i-1].target);
                end
            end
            tick();
        end
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL vector_drain: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tbl [12] = '{32'hFE112E23, 32'h123450B7, 32'h002081B3, 32'h00C000E7,
                                  32'h80002083, 32'h00000073, 32'h0000000F, 32'hFE000EE3,
                                  32'h0000001B, 32'h0000003B, 32'h00004501, 32'h7FFFF06F};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 12) drive(1'b1, tbl[i], 32'h8000_0000 + 32'(i * 4));
            else        drive(1'b0, 32'h0, 32'h0);
            n_chk++;
            if (bus.in_ready !== (mdl_cnt < DEPTH)) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: in_ready=%b want %b", i, bus.in_ready, mdl_cnt < DEPTH);
            end
            n_chk++;
            if (exp_q.size() == 0) begin
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_empty%0d: out_valid=%b want 0", i, bus.out_valid);
                end
            end else if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal}
                         !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL b2b_head%0d: got %h want %h", i,
                         {bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal},
                         {1'b1, exp_q[0]});
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] v_inst [3] = '{32'h00500113, 32'hFFF10193, 32'h00C00223};
        int sent = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (sent < 3) drive(1'b1, v_inst[sent], 32'h40);
            else          drive(1'b0, 32'h0, 32'h0);
            n_chk++;
            if (bus.in_ready !== (mdl_cnt < DEPTH)) begin
                n_fail++;
                $display("FAIL bp_ready%0d: in_ready=%b want %b", cyc, bus.in_ready, mdl_cnt < DEPTH);
            end
            n_chk++;
            if (exp_q.size() == 0) begin
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_empty%0d: out_valid=%b want 0", cyc, bus.out_valid);
                end
            end else if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal}
                         !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL bp_head%0d: got %h want %h", cyc,
                         {bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal},
                         {1'b1, exp_q[0]});
            end
            if (bus.in_valid && mdl_cnt < DEPTH) sent++;
            tick();
        end
        n_chk++;
        if (sent != 3 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_complete: sent=%0d out_valid=%b want 3 0", sent, bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0);
        tick();
        drive(1'b1, 32'h00200113, 32'h0);
        tick();
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: out_valid=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        drive(1'b1, 32'h00300193, 32'h0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        tick();
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: out_valid=%b want 0", bus.out_valid);
        end
        drive(1'b1, 32'h0000000B, 32'h1234);
        pend = '{32'h0, 3'd0, 32'h0, 1'b1};
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_chk++;
        if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal}
            !== {1'b1, 32'h0, 3'd0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL illegal_0b: got v=%b imm=%h fmt=%0d tgt=%h ill=%b want 1 0 0 0 1",
                     bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h0);
        tick();
        drive(1'b1, 32'h0000006F, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_chk++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: out_valid=%b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_now: out_valid=%b in_ready=%b imm=%h want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_imm);
        end
        exp_q.delete();
        mdl_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r, inst;
        for (int i = 0; i < 120; i++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0) inst = r;
            else                           inst = {r[31:7], legal_ops[$urandom_range(0, 10)]};
            if (i < 100) drive($urandom_range(0, 3) != 0, inst, $urandom());
            else         drive(1'b0, 32'h0, 32'h0);
            bus.out_ready = (i >= 100) || ($urandom_range(0, 2) != 0);
            n_chk++;
            if (bus.in_ready !== (mdl_cnt < DEPTH)) begin
                n_fail++;
                $display("FAIL rnd_ready%0d: in_ready=%b want %b", i, bus.in_ready, mdl_cnt < DEPTH);
            end
            n_chk++;
            if (exp_q.size() == 0) begin
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_empty%0d: out_valid=%b want 0", i, bus.out_valid);
                end
            end else if ({bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal}
                         !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL rnd_head%0d: got %h want %h", i,
                         {bus.out_valid, bus.out_imm, bus.out_fmt, bus.out_target, bus.out_illegal},
                         {1'b1, exp_q[0]});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
